operand_stage: RTL and testbench

//  Decode/operand-read stage with the ID/EX pipeline register. Holds the

---
 rtl/operand_stage.sv | 132 +++++++++++++
 tb/tb_operand_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stage.sv
// Decode/operand-read stage: register file, forwarding muxes, load-use
// bubble insertion and the ID/EX pipeline register.
module operand_stage #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic              in_use1,
  input  logic              in_use2,
  input  logic [3:0]        in_rd,
  input  logic              in_wen,
  input  logic              in_is_load,
  output logic              in_ready,
  input  logic [1:0]        MuxCtrl11,
  input  logic [1:0]        MuxCtrl21,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_is_load,
  input  logic              wb_wen,
  input  logic [3:0]        wb_index,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [3:0]        out_rd,
  output logic              out_wen,
  output logic              out_is_load,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {RUN, STALL} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rf_q [16];
  logic [DATA_W-1:0] op_a, op_b;
  logic              haz, stall_go, bubble;
  logic              valid_q, wen_q, load_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [3:0]        rd_q;
  logic [CNT_W-1:0]  cnt_q;

  always_comb begin
    op_a = rf_q[in_rs1];
    unique case (MuxCtrl11)
      2'd2:    op_a = ex_result;
      2'd3:    op_a = wb_result;
      default: op_a = rf_q[in_rs1];
    endcase
  end

  always_comb begin
    op_b = rf_q[in_rs2];
    unique case (MuxCtrl21)
      2'd2:    op_b = ex_result;
      2'd3:    op_b = wb_result;
      default: op_b = rf_q[in_rs2];
    endcase
  end

  assign haz = in_valid & ex_is_load &
               ((in_use1 & (MuxCtrl11 == 2'd2)) |
                (in_use2 & (MuxCtrl21 == 2'd2)));

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (haz && !flush) state_d = STALL;
      STALL:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Hazard is only honoured in RUN; STALL always lets the instruction go.
  always_comb begin
    stall_go = (state_q == RUN) & haz & ~flush;
    bubble   = stall_go | flush;
    in_ready = ~stall_go;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (wb_wen) begin
      rf_q[wb_index] <= wb_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      load_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
    end else if (bubble) begin
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      wen_q   <= in_valid & in_wen;
      load_q  <= in_valid & in_is_load;
      a_q     <= op_a;
      b_q     <= op_b;
      rd_q    <= in_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                         cnt_q <= '0;
    else if (stall_go && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign out_valid   = valid_q;
  assign out_a       = a_q;
  assign out_b       = b_q;
  assign out_rd      = rd_q;
  assign out_wen     = wen_q;
  assign out_is_load = load_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: scoreboard of expected ID/EX contents,
// one entry pushed per driven cycle and popped after the edge.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_use1, in_use2, in_wen, in_is_load;
  logic [3:0]  in_rs1, in_rs2, in_rd;
  logic        in_ready;
  logic [1:0]  MuxCtrl11, MuxCtrl21;
  logic [15:0] ex_result, wb_result;
  logic        ex_is_load, wb_wen, flush;
  logic [3:0]  wb_index;
  logic        out_valid, out_wen, out_is_load;
  logic [15:0] out_a, out_b;
  logic [3:0]  out_rd;
  logic [15:0] stall_cnt;

  logic        s_ready, s_valid, s_wen, s_load;
  logic [15:0] s_a, s_b;
  logic [3:0]  s_rd;
  logic [2:0]  s_cnt;

  always #5 clk = ~clk;

  operand_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use1(in_use1), .in_use2(in_use2), .in_rd(in_rd),
    .in_wen(in_wen), .in_is_load(in_is_load), .in_ready(in_ready),
    .MuxCtrl11(MuxCtrl11), .MuxCtrl21(MuxCtrl21),
    .ex_result(ex_result), .ex_is_load(ex_is_load),
    .wb_wen(wb_wen), .wb_index(wb_index), .wb_result(wb_result),
    .flush(flush), .out_valid(out_valid), .out_a(out_a), .out_b(out_b),
    .out_rd(out_rd), .out_wen(out_wen), .out_is_load(out_is_load),
    .stall_cnt(stall_cnt)
  );

  operand_stage #(.DATA_W(16), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use1(in_use1), .in_use2(in_use2), .in_rd(in_rd),
    .in_wen(in_wen), .in_is_load(in_is_load), .in_ready(s_ready),
    .MuxCtrl11(MuxCtrl11), .MuxCtrl21(MuxCtrl21),
    .ex_result(ex_result), .ex_is_load(ex_is_load),
    .wb_wen(wb_wen), .wb_index(wb_index), .wb_result(wb_result),
    .flush(flush), .out_valid(s_valid), .out_a(s_a), .out_b(s_b),
    .out_rd(s_rd), .out_wen(s_wen), .out_is_load(s_load),
    .stall_cnt(s_cnt)
  );

  typedef struct {
    logic        v;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  rd;
    logic        wen;
    logic        ld;
    logic        full;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push_full(input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] rd,
                           input logic wen, input logic ld);
    exp_t e;
    e.v = v; e.a = a; e.b = b; e.rd = rd;
    e.wen = wen; e.ld = ld; e.full = 1'b1;
    sb.push_back(e);
  endtask

  task automatic push_bub();
    exp_t e;
    e.v = 1'b0; e.a = '0; e.b = '0; e.rd = '0;
    e.wen = 1'b0; e.ld = 1'b0; e.full = 1'b0;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
      chk("out_wen", {31'd0, out_wen}, {31'd0, e.wen});
      chk("out_is_load", {31'd0, out_is_load}, {31'd0, e.ld});
      if (e.full) begin
        chk("out_a", {16'd0, out_a}, {16'd0, e.a});
        chk("out_b", {16'd0, out_b}, {16'd0, e.b});
        chk("out_rd", {28'd0, out_rd}, {28'd0, e.rd});
      end
    end
  endtask

  task automatic dec(input logic v, input logic [3:0] rs1,
                     input logic [3:0] rs2, input logic u1,
                     input logic u2, input logic [1:0] m1,
                     input logic [1:0] m2, input logic [3:0] rd,
                     input logic wen, input logic ld);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2;
    in_use1 = u1; in_use2 = u2;
    MuxCtrl11 = m1; MuxCtrl21 = m2;
    in_rd = rd; in_wen = wen; in_is_load = ld;
  endtask

  task automatic wb(input logic en, input logic [3:0] idx,
                    input logic [15:0] d);
    wb_wen = en; wb_index = idx; wb_result = d;
  endtask

  task automatic ready_is(input string tag, input logic exp);
    #1;
    chk(tag, {31'd0, in_ready}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    ex_is_load = 1'b0; ex_result = '0;
    wb(1'b0, 4'd0, 16'h0);
    dec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    push_full(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    ready_is("rst_ready", 1'b1);

    // regfile write, then read the written value
    wb(1'b1, 4'd5, 16'h1234);
    push_bub();
    tick();
    wb(1'b1, 4'd7, 16'h7777);
    dec(1'b1, 4'd5, 4'd7, 1'b1, 1'b1, 2'd1, 2'd1, 4'd3, 1'b1, 1'b0);
    push_full(1'b1, 16'h1234, 16'h0, 4'd3, 1'b1, 1'b0);
    tick();
    wb(1'b1, 4'd0, 16'hBEEF);
    dec(1'b1, 4'd7, 4'd0, 1'b1, 1'b1, 2'd0, 2'd1, 4'd0, 1'b0, 1'b1);
    push_full(1'b1, 16'h7777, 16'h0, 4'd0, 1'b0, 1'b1);
    tick();
    wb(1'b0, 4'd0, 16'h0);
    dec(1'b1, 4'd0, 4'd5, 1'b1, 1'b1, 2'd1, 2'd0, 4'd15, 1'b1, 1'b0);
    push_full(1'b1, 16'hBEEF, 16'h1234, 4'd15, 1'b1, 1'b0);
    tick();

    // unused operand selecting EX of a load: no stall
    ex_is_load = 1'b1; ex_result = 16'h9999;
    dec(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 2'd1, 2'd2, 4'd1, 1'b1, 1'b0);
    ready_is("unused_ready", 1'b1);
    push_full(1'b1, 16'h1234, 16'h9999, 4'd1, 1'b1, 1'b0);
    tick();
    chk("unused_cnt", {16'd0, stall_cnt}, 32'd0);

    // EX and WB forwarding
    ex_is_load = 1'b0; ex_result = 16'hAAAA;
    wb(1'b0, 4'd0, 16'h5555);
    dec(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 2'd2, 2'd3, 4'd2, 1'b1, 1'b0);
    push_full(1'b1, 16'hAAAA, 16'h5555, 4'd2, 1'b1, 1'b0);
    tick();

    // hazard pattern without a valid instruction
    ex_is_load = 1'b1;
    dec(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 2'd2, 2'd0, 4'd2, 1'b1, 1'b0);
    ready_is("inv_ready", 1'b1);
    push_bub();
    tick();
    chk("inv_cnt", {16'd0, stall_cnt}, 32'd0);

    // load-use: one bubble, then issue with WB data
    ex_result = 16'h1111;
    dec(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 2'd2, 2'd1, 4'd4, 1'b1, 1'b0);
    ready_is("lu_ready0", 1'b0);
    push_bub();
    tick();
    chk("lu_cnt1", {16'd0, stall_cnt}, 32'd1);
    ex_is_load = 1'b0;
    wb(1'b1, 4'd9, 16'h4321);
    dec(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 2'd3, 2'd1, 4'd4, 1'b1, 1'b0);
    ready_is("lu_ready1", 1'b1);
    push_full(1'b1, 16'h4321, 16'hBEEF, 4'd4, 1'b1, 1'b0);
    tick();
    chk("lu_cnt2", {16'd0, stall_cnt}, 32'd1);

    // hazard still present in STALL is not re-evaluated
    wb(1'b0, 4'd0, 16'h0);
    ex_is_load = 1'b1; ex_result = 16'h2222;
    dec(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 2'd2, 2'd1, 4'd6, 1'b1, 1'b0);
    push_bub();
    tick();
    chk("hold_cnt", {16'd0, stall_cnt}, 32'd2);
    ready_is("hold_ready", 1'b1);
    push_full(1'b1, 16'h2222, 16'hBEEF, 4'd6, 1'b1, 1'b0);
    tick();
    chk("hold_cnt2", {16'd0, stall_cnt}, 32'd2);

    // flush in the stall-entry cycle
    flush = 1'b1;
    ready_is("fl_ready", 1'b1);
    push_bub();
    tick();
    flush = 1'b0;
    chk("fl_cnt", {16'd0, stall_cnt}, 32'd2);
    ready_is("fl_run", 1'b0);
    push_bub();
    tick();
    chk("fl_cnt2", {16'd0, stall_cnt}, 32'd3);
    flush = 1'b1;
    ready_is("fl_stall_ready", 1'b1);
    push_bub();
    tick();
    flush = 1'b0;
    ex_is_load = 1'b0;
    dec(1'b1, 4'd5, 4'd0, 1'b1, 1'b1, 2'd1, 2'd1, 4'd8, 1'b1, 1'b1);
    ready_is("post_fl_ready", 1'b1);
    push_full(1'b1, 16'h1234, 16'hBEEF, 4'd8, 1'b1, 1'b1);
    tick();
    flush = 1'b1;
    push_bub();
    tick();
    flush = 1'b0;
    chk("fl_cnt3", {16'd0, stall_cnt}, 32'd3);

    // counter saturation on the narrow instance
    for (int i = 0; i < 10; i++) begin
      ex_is_load = 1'b1;
      dec(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 2'd2, 2'd1, 4'd3, 1'b1, 1'b0);
      push_bub();
      tick();
      ex_is_load = 1'b0;
      dec(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 2'd1, 2'd1, 4'd3, 1'b1, 1'b0);
      push_full(1'b1, 16'h1234, 16'hBEEF, 4'd3, 1'b1, 1'b0);
      tick();
    end
    chk("sat_cnt", {16'd0, stall_cnt}, 32'd13);
    chk("sat_cnt_s", {29'd0, s_cnt}, 32'd7);

    // reset during STALL
    ex_is_load = 1'b1;
    dec(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 2'd2, 2'd1, 4'd3, 1'b1, 1'b0);
    push_bub();
    tick();
    chk("pre_rst_cnt", {16'd0, stall_cnt}, 32'd14);
    rst = 1'b1;
    push_full(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    chk("mid_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("mid_rst_cnt_s", {29'd0, s_cnt}, 32'd0);
    ex_is_load = 1'b0;
    dec(1'b1, 4'd5, 4'd0, 1'b1, 1'b1, 2'd1, 2'd0, 4'd2, 1'b1, 1'b0);
    ready_is("mid_rst_ready", 1'b1);
    push_full(1'b1, 16'h0, 16'h0, 4'd2, 1'b1, 1'b0);
    tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
